// File: rtl/cmac_axis_pkg.sv
// Shared types and constants for the CMAC-side AXI4-Stream blocks.
package cmac_axis_pkg;

  localparam int CMAC_DATA_WIDTH = 512;
  localparam int CMAC_KEEP_WIDTH = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice; the input-side ready is a registered
// free-space flag so upstream never sees a combinational path.
module axis_skid_buffer
  import cmac_axis_pkg::*;
#(
  parameter int DATA_WIDTH = CMAC_DATA_WIDTH,
  parameter int KEEP_WIDTH = CMAC_KEEP_WIDTH,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [KEEP_WIDTH-1:0] s_keep,
  input  logic                  s_last,
  input  logic [ID_WIDTH-1:0]   s_id,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [KEEP_WIDTH-1:0] m_keep,
  output logic                  m_last,
  output logic [ID_WIDTH-1:0]   m_id
);

  localparam int PW = DATA_WIDTH + KEEP_WIDTH + ID_WIDTH + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] spare;
  logic [PW-1:0] din;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic          free;
  logic          push;
  logic          pop;

  assign din     = {s_last, s_id, s_keep, s_data};
  assign push    = s_valid & free;
  assign m_valid = (count != 2'd0);
  assign pop     = m_valid & m_ready;
  assign s_ready = free;

  assign {m_last, m_id, m_keep, m_data} = head;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      free  <= 1'b1;
      head  <= '0;
      spare <= '0;
    end else begin
      count <= count_nxt;
      free  <= (count_nxt != 2'd2);
      // Head always holds the oldest beat; spare only fills on a stall.
      if (count == 2'd2) begin
        if (pop) head <= spare;
      end else if (push && (count == 2'd0 || pop)) begin
        head <= din;
      end else if (push) begin
        spare <= din;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS AXI4-Stream
// sources onto one output; grants are held from first beat to tlast.
module axis_pkt_rr_arbiter
  import cmac_axis_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = CMAC_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = clog2(NUM_PORTS)
) (
  input  logic                            axis_aclk,
  input  logic                            axis_areset,
  input  logic [NUM_PORTS-1:0]            port_en,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [ID_WIDTH-1:0]             m_axis_tid,
  output logic                            grant_active,
  output logic [ID_WIDTH-1:0]             grant_idx
);

  arb_state_t            state;
  arb_state_t            state_nxt;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   rr_nxt;
  logic [ID_WIDTH-1:0]   grant_nxt;
  logic [NUM_PORTS-1:0]  req;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_hit;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic                  free;
  logic                  accept;

  assign req          = s_axis_tvalid & port_en;
  assign grant_active = (state == BUSY);
  assign accept       = grant_active & free & sel_valid;

  // Scan upward from rr_ptr, wrapping, for the first requester.
  always_comb begin
    int j;
    j        = 0;
    pick_hit = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = (int'(rr_ptr) + k) % NUM_PORTS;
      if (!pick_hit && req[j]) begin
        pick_hit = 1'b1;
        pick_idx = ID_WIDTH'(j);
      end
    end
  end

  always_comb begin
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    sel_keep      = '0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx == ID_WIDTH'(i)) begin
        sel_valid        = s_axis_tvalid[i];
        sel_last         = s_axis_tlast[i];
        sel_data         = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep         = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        s_axis_tready[i] = grant_active & free;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_hit) begin
          state_nxt = BUSY;
          grant_nxt = pick_idx;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_nxt = IDLE;
          if (grant_idx == ID_WIDTH'(NUM_PORTS - 1))
            rr_nxt = '0;
          else
            rr_nxt = grant_idx + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      grant_idx <= grant_nxt;
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH),
    .ID_WIDTH  (ID_WIDTH)
  ) u_skid (
    .clk    (axis_aclk),
    .rst    (axis_areset),
    .s_valid(accept),
    .s_ready(free),
    .s_data (sel_data),
    .s_keep (sel_keep),
    .s_last (sel_last),
    .s_id   (grant_idx),
    .m_valid(m_axis_tvalid),
    .m_ready(m_axis_tready),
    .m_data (m_axis_tdata),
    .m_keep (m_axis_tkeep),
    .m_last (m_axis_tlast),
    .m_id   (m_axis_tid)
  );

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter: arbitration vector table
// plus hand-written multi-cycle sequences, with an in-order scoreboard.
module tb_axis_pkt_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [N-1:0]  port_en;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tready;
  logic [N-1:0]  s_tlast;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic [IW-1:0] m_tid;
  logic          grant_active;
  logic [IW-1:0] grant_idx;

  axis_pkt_rr_arbiter #(
    .NUM_PORTS (N),
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .ID_WIDTH  (IW)
  ) dut (
    .axis_aclk    (clk),
    .axis_areset  (rst),
    .port_en      (port_en),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tlast (s_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .m_axis_tid   (m_tid),
    .grant_active (grant_active),
    .grant_idx    (grant_idx)
  );

  typedef struct {
    int          tid;
    logic [15:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] en;
    logic       act;
    logic [1:0] gnt;
  } vec_t;

  beat_t sb[$];
  int    last_tids[$];
  vec_t  vecs[10];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_count = 0;
  int out_count = 0;
  int cur_port = -1;
  int last_end = -1;
  bit gap_chk = 1'b0;

  int          left[N];
  int          len[N];
  int          beat[N];
  logic [15:0] base[N];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i] = (left[i] > 0);
      s_tlast[i]  = (beat[i] == len[i] - 1);
      s_tdata[i*DW +: DW] = DW'(base[i] + 16'(beat[i]));
      s_tkeep[i*KW +: KW] = '1;
    end
  endtask

  task automatic src(input int i, input int npk, input int l,
                     input logic [15:0] b);
    left[i] = npk;
    len[i]  = l;
    beat[i] = 0;
    base[i] = b;
  endtask

  function automatic bit busy();
    bit r;
    r = (sb.size() != 0) || m_tvalid;
    for (int i = 0; i < N; i++) if (left[i] > 0) r = 1'b1;
    return r;
  endfunction

  // One clock: observe handshakes at the falling edge, update sources
  // just after the rising edge.
  task automatic cycle();
    bit    acc[N];
    int    nacc;
    beat_t e;
    nacc = 0;
    @(negedge clk);
    cyc++;
    if (m_tvalid && m_tready) begin
      out_count++;
      if (sb.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("out_tid", m_tid, e.tid);
        chk("out_data", m_tdata[15:0], e.data);
        chk("out_last", m_tlast, e.last);
        if (m_tlast) last_tids.push_back(int'(m_tid));
      end
    end
    for (int i = 0; i < N; i++) begin
      acc[i] = s_tvalid[i] && s_tready[i];
      if (acc[i]) begin
        nacc++;
        acc_count++;
        e.tid  = i;
        e.data = base[i] + 16'(beat[i]);
        e.last = (beat[i] == len[i] - 1);
        sb.push_back(e);
        if (cur_port >= 0) chk("no_interleave", i, cur_port);
        if (gap_chk && beat[i] == 0 && last_end >= 0)
          chk("idle_gap", cyc - last_end, 2);
        if (e.last) begin
          cur_port = -1;
          last_end = cyc;
        end else begin
          cur_port = i;
        end
      end
    end
    chk("single_accept", (nacc <= 1), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          left[i]--;
          base[i] += 16'h10;
        end else begin
          beat[i]++;
        end
      end
    end
    drive();
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while (busy() && n < max) begin
      cycle();
      n++;
    end
    chk("drain_done", busy(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      beat[i] = 0;
      len[i]  = 1;
      base[i] = '0;
    end
    drive();
    sb.delete();
    cur_port = -1;
    last_end = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ga_exp[4];
    int   acc0;
    int   out0;

    rst      = 1'b1;
    port_en  = '1;
    m_tready = 1'b1;
    s_tdata  = '0;

    // req, port_en, expected grant_active, expected grant_idx
    vecs[0] = '{4'b0000, 4'b1111, 1'b0, 2'd0};
    vecs[1] = '{4'b1111, 4'b0000, 1'b0, 2'd0};
    vecs[2] = '{4'b0100, 4'b1111, 1'b1, 2'd2};
    vecs[3] = '{4'b0011, 4'b1111, 1'b1, 2'd0};
    vecs[4] = '{4'b1101, 4'b1111, 1'b1, 2'd2};
    vecs[5] = '{4'b1111, 4'b0111, 1'b1, 2'd0};
    vecs[6] = '{4'b1001, 4'b1111, 1'b1, 2'd3};
    vecs[7] = '{4'b0010, 4'b1101, 1'b0, 2'd3};
    vecs[8] = '{4'b1010, 4'b1111, 1'b1, 2'd1};
    vecs[9] = '{4'b0011, 4'b1111, 1'b1, 2'd0};

    do_reset();
    chk("rst_tready", s_tready, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_active", grant_active, 0);
    chk("rst_gidx", grant_idx, 0);
    chk("rst_mdata", (m_tdata == '0), 1);
    chk("rst_mkeep", (m_tkeep == '0), 1);
    chk("rst_mlast", m_tlast, 0);
    chk("rst_mtid", m_tid, 0);

    foreach (vecs[v]) begin
      port_en = vecs[v].en;
      for (int i = 0; i < N; i++)
        if (vecs[v].req[i]) src(i, 1, 1, 16'(16'h100 * (v + 1) + i));
      drive();
      cycle();
      chk($sformatf("tbl%0d_active", v), grant_active, vecs[v].act);
      chk($sformatf("tbl%0d_gidx", v), grant_idx, vecs[v].gnt);
      for (int i = 0; i < N; i++)
        if (!(vecs[v].act && i == int'(vecs[v].gnt))) left[i] = 0;
      drive();
      repeat (3) cycle();
    end
    chk("tbl_drained", sb.size(), 0);

    // Port 2, three beats A0..A2.
    do_reset();
    port_en = '1;
    src(2, 1, 3, 16'hA0);
    drive();
    chk("t1_idle", grant_active, 0);
    cycle();
    chk("t1_active", grant_active, 1);
    chk("t1_gidx", grant_idx, 2);
    chk("t1_tready", s_tready, 4'b0100);
    chk("t1_mvalid0", m_tvalid, 0);
    cycle();
    chk("t1_mvalid", m_tvalid, 1);
    chk("t1_tid", m_tid, 2);
    chk("t1_b0", m_tdata[15:0], 16'hA0);
    chk("t1_b0_last", m_tlast, 0);
    cycle();
    chk("t1_b1", m_tdata[15:0], 16'hA1);
    cycle();
    chk("t1_b2", m_tdata[15:0], 16'hA2);
    chk("t1_b2_last", m_tlast, 1);
    chk("t1_back_idle", grant_active, 0);
    // rr_ptr is now 3, so port 3 wins over port 0.
    src(0, 1, 1, 16'h300);
    src(3, 1, 1, 16'h330);
    drive();
    cycle();
    chk("t1_rr_gidx", grant_idx, 3);
    drain(20);

    // All ports streaming 2-beat packets.
    do_reset();
    last_tids.delete();
    port_en = '1;
    for (int i = 0; i < N; i++) src(i, 2, 2, 16'((i + 1) << 8));
    gap_chk = 1'b1;
    drive();
    drain(80);
    gap_chk = 1'b0;
    chk("t2_pkts", last_tids.size(), 8);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t2_order%0d", k),
          (k < last_tids.size()) ? last_tids[k] : -1, k % 4);

    // Output stall with port 1 mid-packet.
    do_reset();
    m_tready = 1'b0;
    src(1, 1, 4, 16'h500);
    drive();
    acc0 = acc_count;
    out0 = out_count;
    cycle();
    chk("t3_tready", s_tready, 4'b0010);
    cycle();
    cycle();
    chk("t3_full_tready", s_tready, 0);
    chk("t3_buffered", acc_count - acc0, 2);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_hold_tready", s_tready, 0);
      chk("t3_hold_valid", m_tvalid, 1);
      chk("t3_hold_data", m_tdata[15:0], 16'h500);
      chk("t3_hold_tid", m_tid, 1);
      chk("t3_hold_last", m_tlast, 0);
    end
    chk("t3_still2", acc_count - acc0, 2);
    m_tready = 1'b1;
    drain(30);
    chk("t3_in_total", acc_count - acc0, 4);
    chk("t3_out_total", out_count - out0, 4);

    // port_en[1] dropped mid-packet.
    do_reset();
    last_tids.delete();
    port_en = '1;
    src(1, 1, 3, 16'h600);
    drive();
    cycle();
    cycle();
    port_en = 4'b1101;
    drive();
    drain(20);
    chk("t4_pkts", last_tids.size(), 1);
    chk("t4_port1", (last_tids.size() > 0) ? last_tids[0] : -1, 1);
    src(1, 1, 1, 16'h700);
    drive();
    repeat (4) cycle();
    chk("t4_skip_active", grant_active, 0);
    chk("t4_skip_gidx", grant_idx, 1);
    src(0, 1, 1, 16'h710);
    drive();
    repeat (6) cycle();
    chk("t4_pkts2", last_tids.size(), 2);
    chk("t4_port0", (last_tids.size() > 1) ? last_tids[1] : -1, 0);
    chk("t4_final_idle", grant_active, 0);
    chk("t4_port1_waiting", left[1], 1);
    left[1] = 0;
    port_en = '1;
    drive();

    // Back-to-back single-beat packets on ports 0 and 3.
    do_reset();
    last_tids.delete();
    src(0, 1, 1, 16'h800);
    src(3, 1, 1, 16'h830);
    drive();
    ga_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("t5_active%0d", k), grant_active, ga_exp[k]);
      if (k == 2) chk("t5_gidx3", grant_idx, 3);
    end
    drain(20);
    chk("t5_pkts", last_tids.size(), 2);
    chk("t5_tid0", (last_tids.size() > 0) ? last_tids[0] : -1, 0);
    chk("t5_tid1", (last_tids.size() > 1) ? last_tids[1] : -1, 3);

    // Reset during beat 2 of a 4-beat packet.
    do_reset();
    src(1, 1, 4, 16'h900);
    src(3, 1, 1, 16'h930);
    drive();
    cycle();
    cycle();
    cycle();
    chk("t6_pre_valid", m_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_tready", s_tready, 0);
    chk("t6_rst_mvalid", m_tvalid, 0);
    chk("t6_rst_active", grant_active, 0);
    chk("t6_rst_mdata", (m_tdata == '0), 1);
    sb.delete();
    beat[1]  = 0;
    cur_port = -1;
    last_end = -1;
    drive();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("t6_regrant_active", grant_active, 1);
    chk("t6_regrant_gidx", grant_idx, 1);
    drain(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
